// File: rtl/jk_ff_checker_if.sv
// ----------------------------------------------------------------------------
// jk_ff_checker_if
// Bundle of everything the JK flip-flop checker observes and reports.
//
//   Observed / control (driven by the bench or self-test wrapper):
//     en       checking enable
//     clr      synchronous clear of counters, coverage and fail
//     dut_rst  copy of the flip-flop's synchronous reset
//     j, k     flip-flop J/K inputs
//     q, q_bar flip-flop outputs
//   Reported (driven by the checker):
//     busy       1 while synchronising or checking
//     err_pulse  one-cycle strobe per mismatching compare
//     fail       sticky failure flag
//     err_cnt    saturating count of mismatching compares
//     chk_cnt    saturating count of compares performed
//     cov        sticky JK-mode coverage {toggle, set, reset, hold}
//
// master: the side that drives stimulus and reads results.
// slave : the checker itself.
// ----------------------------------------------------------------------------
interface jk_ff_checker_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             dut_rst;
    logic             j;
    logic             k;
    logic             q;
    logic             q_bar;
    logic             busy;
    logic             err_pulse;
    logic             fail;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] chk_cnt;
    logic [3:0]       cov;

    modport master (
        output en, clr, dut_rst, j, k, q, q_bar,
        input  busy, err_pulse, fail, err_cnt, chk_cnt, cov
    );

    modport slave (
        input  en, clr, dut_rst, j, k, q, q_bar,
        output busy, err_pulse, fail, err_cnt, chk_cnt, cov
    );
endinterface

// File: rtl/jk_ff_checker.sv
// ----------------------------------------------------------------------------
// jk_ff_checker
// Passive, cycle-accurate checker for a rising-edge JK flip-flop with a
// synchronous reset. It watches the same J/K/reset stimulus as the flip-flop,
// keeps a one-bit reference model of Q and compares it with the observed
// Q / Q_bar on every clock while checking is enabled.
//
// Ports:
//   clk  in   checker clock, same rising edge as the flip-flop
//   rst  in   asynchronous active-high reset of the checker
//   bus  slave modport of jk_ff_checker_if (observed signals + results)
//
// Parameters:
//   CNT_W    width of err_cnt / chk_cnt, both saturate at 2^CNT_W-1
//   MAX_ERR  err_cnt value that moves the checker into its FAIL state
//
// All outputs are registered. Edge priority: rst > clr > dut_rst > normal.
// ----------------------------------------------------------------------------
module jk_ff_checker #(
    parameter int CNT_W   = 8,
    parameter int MAX_ERR = 1
) (
    input  logic            clk,
    input  logic            rst,
    jk_ff_checker_if.slave  bus
);

    localparam logic [CNT_W-1:0] MAX_ERR_C = CNT_W'(MAX_ERR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_CHECK = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    state_t           state;
    logic             exp_q;
    logic             busy_r;
    logic             err_pulse_r;
    logic             fail_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic [CNT_W-1:0] chk_cnt_r;
    logic [3:0]       cov_r;

    logic             mism;
    logic [CNT_W-1:0] err_next;

    // JK next-state function: 00 hold, 01 reset, 10 set, 11 toggle.
    function automatic logic nx(input logic x, input logic jj, input logic kk);
        logic r;
        case ({jj, kk})
            2'b00:   r = x;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            default: r = ~x;
        endcase
        return r;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // A compare fails if Q disagrees with the model or Q_bar is not ~Q.
    assign mism     = (bus.q != exp_q) || (bus.q_bar != ~bus.q);
    assign err_next = sat_inc(err_cnt_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            exp_q       <= 1'b0;
            busy_r      <= 1'b0;
            err_pulse_r <= 1'b0;
            fail_r      <= 1'b0;
            err_cnt_r   <= '0;
            chk_cnt_r   <= '0;
            cov_r       <= 4'b0000;
        end else if (bus.clr) begin
            // exp_q deliberately survives a clear.
            state       <= S_IDLE;
            busy_r      <= 1'b0;
            err_pulse_r <= 1'b0;
            fail_r      <= 1'b0;
            err_cnt_r   <= '0;
            chk_cnt_r   <= '0;
            cov_r       <= 4'b0000;
        end else begin
            err_pulse_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.en) begin
                        state  <= S_SYNC;
                        busy_r <= 1'b1;
                    end
                end

                // One edge with no compare: align the model to the observed Q.
                S_SYNC: begin
                    exp_q <= bus.dut_rst ? 1'b0 : nx(bus.q, bus.j, bus.k);
                    if (bus.en) begin
                        state  <= S_CHECK;
                        busy_r <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end
                end

                S_CHECK: begin
                    if (!bus.en) begin
                        // Dropping enable wins over a simultaneous mismatch.
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        chk_cnt_r <= sat_inc(chk_cnt_r);
                        if (mism) begin
                            err_pulse_r <= 1'b1;
                            err_cnt_r   <= err_next;
                            if (err_next == MAX_ERR_C) begin
                                state  <= S_FAIL;
                                fail_r <= 1'b1;
                                busy_r <= 1'b0;
                            end
                        end
                        // Model follows the observed Q so a single bad edge
                        // is reported once rather than propagating.
                        if (bus.dut_rst) begin
                            exp_q <= 1'b0;
                        end else begin
                            cov_r[{bus.j, bus.k}] <= 1'b1;
                            exp_q <= nx(bus.q, bus.j, bus.k);
                        end
                    end
                end

                S_FAIL: begin
                    fail_r <= 1'b1;
                    busy_r <= 1'b0;
                end

                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.err_pulse = err_pulse_r;
    assign bus.fail      = fail_r;
    assign bus.err_cnt   = err_cnt_r;
    assign bus.chk_cnt   = chk_cnt_r;
    assign bus.cov       = cov_r;

endmodule

// File: tb/tb_jk_ff_checker.sv
// ----------------------------------------------------------------------------
// tb_jk_ff_checker
// Table-driven bench for jk_ff_checker. Two instances share one stimulus
// set: u0 (CNT_W=8, MAX_ERR=3) and u1 (CNT_W=2, MAX_ERR=3, for saturation).
// Each table row gives the inputs applied before a rising edge and the
// hand-computed outputs expected just after it. The observed q/q_bar
// values in the tables are those of a correct JK flip-flop unless a fault
// is being injected.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jk_ff_checker;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic en = 1'b0, clr = 1'b0, dut_rst = 1'b0, j = 1'b0, k = 1'b0;
    logic q = 1'b0, q_bar = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_ff_checker_if #(.CNT_W(8)) if0 ();
    jk_ff_checker_if #(.CNT_W(2)) if1 ();

    assign if0.en = en;      assign if1.en = en;
    assign if0.clr = clr;    assign if1.clr = clr;
    assign if0.dut_rst = dut_rst; assign if1.dut_rst = dut_rst;
    assign if0.j = j;        assign if1.j = j;
    assign if0.k = k;        assign if1.k = k;
    assign if0.q = q;        assign if1.q = q;
    assign if0.q_bar = q_bar; assign if1.q_bar = q_bar;

    jk_ff_checker #(.CNT_W(8), .MAX_ERR(3)) u0 (.clk(clk), .rst(rst0), .bus(if0));
    jk_ff_checker #(.CNT_W(2), .MAX_ERR(3)) u1 (.clk(clk), .rst(rst1), .bus(if1));

    typedef struct {
        bit       s;
        bit       en, clr, dr, j, k, q, qb;
        bit       busy, ep, fl;
        int       ec, cc;
        logic [3:0] cov;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit s, en_i, clr_i, dr, j_i, k_i, q_i, qb,
                       busy, ep, fl, input int ec, cc, input logic [3:0] cov);
        vec_t v;
        v.s = s; v.en = en_i; v.clr = clr_i; v.dr = dr; v.j = j_i; v.k = k_i;
        v.q = q_i; v.qb = qb; v.busy = busy; v.ep = ep; v.fl = fl;
        v.ec = ec; v.cc = cc; v.cov = cov;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string nm, input bit s, input bit busy, ep, fl,
                       input int ec, cc, input logic [3:0] cov);
        bit gb, gep, gfl;
        int gec, gcc;
        logic [3:0] gcov;
        if (s) begin
            gb = if1.busy; gep = if1.err_pulse; gfl = if1.fail;
            gec = int'(if1.err_cnt); gcc = int'(if1.chk_cnt); gcov = if1.cov;
        end else begin
            gb = if0.busy; gep = if0.err_pulse; gfl = if0.fail;
            gec = int'(if0.err_cnt); gcc = int'(if0.chk_cnt); gcov = if0.cov;
        end
        checks++;
        if (gb !== busy || gep !== ep || gfl !== fl || gec != ec || gcc != cc || gcov !== cov) begin
            errors++;
            $display("FAIL %s: busy/pulse/fail/err/chk/cov got %0b/%0b/%0b/%0d/%0d/%b expected %0b/%0b/%0b/%0d/%0d/%b",
                     nm, gb, gep, gfl, gec, gcc, gcov, busy, ep, fl, ec, cc, cov);
        end
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            en = vecs[i].en; clr = vecs[i].clr; dut_rst = vecs[i].dr;
            j = vecs[i].j; k = vecs[i].k; q = vecs[i].q; q_bar = vecs[i].qb;
            @(posedge clk);
            #1;
            cmp($sformatf("%s_row%0d", tag, i), vecs[i].s, vecs[i].busy, vecs[i].ep,
                vecs[i].fl, vecs[i].ec, vecs[i].cc, vecs[i].cov);
        end
        vecs.delete();
    endtask

    initial begin
        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_u0", 1'b0, 0, 0, 0, 0, 0, 4'b0000);
        cmp("reset_u1", 1'b1, 0, 0, 0, 0, 0, 4'b0000);
        @(negedge clk);
        rst0 = 1'b0;

        //   s en cl dr j k q qb | busy ep fl ec cc cov
        // Clean sequence: sync, dut_rst, then all four JK modes.
        add(0, 1,0,0, 0,0, 0,1,  1,0,0, 0, 0, 4'b0000);
        add(0, 1,0,1, 0,0, 0,1,  1,0,0, 0, 0, 4'b0000);
        add(0, 1,0,0, 0,0, 0,1,  1,0,0, 0, 1, 4'b0001);
        add(0, 1,0,0, 0,1, 0,1,  1,0,0, 0, 2, 4'b0011);
        add(0, 1,0,0, 1,0, 0,1,  1,0,0, 0, 3, 4'b0111);
        add(0, 1,0,0, 1,1, 1,0,  1,0,0, 0, 4, 4'b1111);
        add(0, 1,0,0, 1,1, 0,1,  1,0,0, 0, 5, 4'b1111);
        add(0, 1,0,0, 1,0, 1,0,  1,0,0, 0, 6, 4'b1111);
        add(0, 1,0,0, 0,1, 1,0,  1,0,0, 0, 7, 4'b1111);
        add(0, 1,0,0, 0,0, 0,1,  1,0,0, 0, 8, 4'b1111);
        // Injected fault: q forced to 1 for one edge after a reset edge.
        add(0, 1,0,0, 0,1, 0,1,  1,0,0, 0, 9, 4'b1111);
        add(0, 1,0,0, 0,1, 1,0,  1,1,0, 1,10, 4'b1111);
        add(0, 1,0,0, 0,0, 0,1,  1,0,0, 1,11, 4'b1111);
        add(0, 1,0,0, 1,0, 0,1,  1,0,0, 1,12, 4'b1111);
        add(0, 1,0,0, 0,0, 1,0,  1,0,0, 1,13, 4'b1111);
        // Clear, resync, then complement fault q_bar == q for three edges.
        add(0, 1,1,0, 0,0, 1,0,  0,0,0, 0, 0, 4'b0000);
        add(0, 1,0,0, 0,0, 1,0,  1,0,0, 0, 0, 4'b0000);
        add(0, 1,0,0, 0,0, 1,0,  1,0,0, 0, 0, 4'b0000);
        add(0, 1,0,0, 0,0, 1,1,  1,1,0, 1, 1, 4'b0001);
        add(0, 1,0,0, 0,0, 1,1,  1,1,0, 2, 2, 4'b0001);
        add(0, 1,0,0, 0,0, 1,1,  0,1,1, 3, 3, 4'b0001);
        add(0, 1,0,0, 0,0, 1,0,  0,0,1, 3, 3, 4'b0001);
        add(0, 1,0,0, 0,0, 1,1,  0,0,1, 3, 3, 4'b0001);
        add(0, 1,1,0, 0,0, 1,0,  0,0,0, 0, 0, 4'b0000);
        // Enable gating with a wrong q while disabled.
        add(0, 1,0,0, 0,0, 1,0,  1,0,0, 0, 0, 4'b0000);
        add(0, 1,0,0, 0,0, 1,0,  1,0,0, 0, 0, 4'b0000);
        add(0, 1,0,0, 0,0, 1,0,  1,0,0, 0, 1, 4'b0001);
        add(0, 0,0,0, 0,0, 0,1,  0,0,0, 0, 1, 4'b0001);
        add(0, 0,0,0, 0,0, 0,0,  0,0,0, 0, 1, 4'b0001);
        add(0, 0,0,0, 0,0, 0,0,  0,0,0, 0, 1, 4'b0001);
        add(0, 0,0,0, 0,0, 0,0,  0,0,0, 0, 1, 4'b0001);
        add(0, 1,0,0, 0,0, 0,1,  1,0,0, 0, 1, 4'b0001);
        add(0, 1,0,0, 1,0, 0,1,  1,0,0, 0, 1, 4'b0001);
        add(0, 1,0,0, 0,0, 1,0,  1,0,0, 0, 2, 4'b0001);
        // dut_rst during CHECK: compare made, model cleared, cov untouched.
        add(0, 1,0,1, 1,0, 1,0,  1,0,0, 0, 3, 4'b0001);
        add(0, 1,0,0, 0,0, 0,1,  1,0,0, 0, 4, 4'b0001);
        // Two single-edge faults to bring err_cnt to 2.
        add(0, 1,0,0, 0,0, 1,0,  1,1,0, 1, 5, 4'b0001);
        add(0, 1,0,0, 0,0, 0,1,  1,1,0, 2, 6, 4'b0001);
        run_table("u0");

        // Asynchronous reset between edges while checking with err_cnt=2.
        @(negedge clk);
        rst0 = 1'b1;
        #1;
        cmp("async_rst_now", 1'b0, 0, 0, 0, 0, 0, 4'b0000);
        #1;
        rst0 = 1'b0;
        @(posedge clk);
        #1;
        cmp("after_async_rst", 1'b0, 1, 0, 0, 0, 0, 4'b0000);

        // Saturation on the narrow instance.
        @(negedge clk);
        en = 1'b0;
        rst1 = 1'b0;
        add(1, 1,0,0, 0,0, 0,1,  1,0,0, 0, 0, 4'b0000);
        add(1, 1,0,0, 0,0, 0,1,  1,0,0, 0, 0, 4'b0000);
        add(1, 1,0,0, 0,0, 0,1,  1,0,0, 0, 1, 4'b0001);
        add(1, 1,0,0, 0,0, 0,1,  1,0,0, 0, 2, 4'b0001);
        add(1, 1,0,0, 0,0, 0,1,  1,0,0, 0, 3, 4'b0001);
        add(1, 1,0,0, 0,0, 0,1,  1,0,0, 0, 3, 4'b0001);
        add(1, 1,0,0, 0,0, 0,1,  1,0,0, 0, 3, 4'b0001);
        add(1, 1,0,0, 0,0, 0,1,  1,0,0, 0, 3, 4'b0001);
        add(1, 1,0,0, 0,0, 0,0,  1,1,0, 1, 3, 4'b0001);
        add(1, 1,0,0, 0,0, 0,0,  1,1,0, 2, 3, 4'b0001);
        add(1, 1,0,0, 0,0, 0,0,  0,1,1, 3, 3, 4'b0001);
        add(1, 1,0,0, 0,0, 0,1,  0,0,1, 3, 3, 4'b0001);
        run_table("u1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_ff_checker.md
Name: jk_ff_checker

Overview:
Passive cycle-accurate checker for a rising-edge JK flip-flop with synchronous reset (jk_ff interface: J, K, Q, Q_bar, rst).
- Observes the same J/K/reset stimulus the flip-flop sees.
- Keeps a reference model of Q and compares it with the flip-flop's Q/Q_bar every clock.
- Reports mismatches, an error count, check count, JK-mode coverage and a sticky fail flag.
- Sits beside the flip-flop in benches and in FPGA self-test wrappers; fully synthesizable.

Parameters:
CNT_W, 8, width of err_cnt and chk_cnt (both saturate at 2^CNT_W-1)
MAX_ERR, 1, err_cnt value at which FAIL is entered (1..2^CNT_W-1)

Ports:
clk  in  1  checker clock, same clock as the flip-flop, rising edge
rst  in  1  checker reset, asynchronous, active-high
en  in  1  checking enable
clr  in  1  synchronous clear of counters, coverage and fail
dut_rst  in  1  copy of the flip-flop's synchronous reset
j  in  1  flip-flop J input
k  in  1  flip-flop K input
q  in  1  flip-flop Q output
q_bar  in  1  flip-flop Q_bar output
busy  out  1  1 while in SYNC or CHECK
err_pulse  out  1  one-cycle strobe on a detected mismatch
fail  out  1  sticky, 1 in FAIL
err_cnt  out  CNT_W  number of mismatching compare cycles
chk_cnt  out  CNT_W  number of compare cycles performed
cov  out  4  sticky coverage bits [0]=hold 00, [1]=reset 01, [2]=set 10, [3]=toggle 11

Behaviour:
- All outputs are registered. Priority at each edge is rst > clr > dut_rst > normal operation.
- Async reset, rst=1:
  - state=IDLE, exp_q=0.
  - busy=0, err_pulse=0, fail=0, err_cnt=0, chk_cnt=0, cov=0.
  - Takes effect immediately, including mid-check.
- Next-state function nx(x,j,k): 00 -> x, 01 -> 0, 10 -> 1, 11 -> ~x.
- IDLE:
  - en=1 -> SYNC.
  - Otherwise stay; dut_rst is ignored; counters hold.
- SYNC (one edge, no comparison):
  - exp_q <= nx(q,j,k); the model aligns to the observed value.
  - dut_rst=1 instead gives exp_q <= 0.
  - Goes to CHECK, or to IDLE if en=0.
- CHECK, each rising edge:
  - Compare q against exp_q and q_bar against ~q.
  - Either mismatch gives err_pulse=1 next cycle and err_cnt+1 (saturating).
  - chk_cnt+1 every compare (saturating).
  - If dut_rst=0, set cov[{j,k}] and load exp_q <= nx(q,j,k). Because the model resyncs to the observed q, a single corrupted edge counts once.
  - If dut_rst=1: the compare is still made, exp_q <= 0, and cov is untouched.
  - en=0 -> IDLE with no compare that edge; counters hold.
  - err_cnt reaching MAX_ERR on this edge -> FAIL, and fail=1 in the same cycle err_pulse rises.
- FAIL:
  - No compares, counters frozen, fail=1.
  - Leaves only on rst, or on clr -> IDLE.
- clr=1 (synchronous):
  - err_cnt=0, chk_cnt=0, cov=0, fail=0, err_pulse=0, state=IDLE.
  - exp_q is unchanged.
- Saturation: at 2^CNT_W-1 a counter holds; err_cnt saturation does not itself cause FAIL unless MAX_ERR is reached.
- Simultaneous en falling and mismatch: en=0 wins; no compare.
- Latency: a mismatch sampled at edge n shows on err_pulse and err_cnt after edge n, i.e. visible during cycle n+1.
- Inputs are assumed synchronous to clk and stable around the rising edge; no internal synchronizers.

Test Plan:
1. Clean sequence: rst pulse, en=1, dut_rst for 1 cycle, then JK = 00,01,10,11,11,10,01 against a correct jk_ff -> err_cnt=0, fail=0, cov=4'b1111, chk_cnt=8.
2. Injected fault with MAX_ERR=3: force q to 1 for one cycle after a 01 (reset) edge -> err_pulse high exactly 1 cycle, err_cnt=1, fail=0, later compares clean.
3. Complement fault: tie q_bar=q for 3 cycles with MAX_ERR=3 -> err_cnt=3, fail=1 in the cycle of the third pulse, err_cnt and chk_cnt frozen afterwards; clr=1 -> fail=0, counters 0, busy=0.
4. Enable gating: drop en for 4 cycles while feeding a wrong q -> no err_pulse, chk_cnt unchanged; raise en -> one SYNC cycle with no compare, then checking resumes with err_cnt=0.
5. Async reset mid-check: assert rst between clock edges during CHECK with err_cnt=2 -> all outputs 0 immediately, before the next edge; busy=0.
6. Saturation with CNT_W=2, MAX_ERR=3: run 6 clean compares -> chk_cnt holds at 3 with no wrap; 3 faults -> err_cnt=3 and fail=1.
